dac_serial_tx: RTL and testbench
================================

# dac_serial_tx

Serial DAC transmitter for the audio output path: accepts 12-bit samples over a valid/ready handshake and, once per 44.1 kHz frame, shifts each sample out MSB-first to a DAC121S101-class serial DAC (SYNC/SCLK/DIN). It is the output-side counterpart of the sample-rate clock and ADC capture logic. It owns its own frame timing, so it runs at the same sample rate as the capture side without external strobes.

## Interface
- FRAME_CYCLES, 2268: clk cycles per frame. 100 MHz / 2268 ≈ 44.09 kHz.
- SCLK_HALF, 2: clk cycles per SCLK half-period. Must be ≥1; 16·2·SCLK_HALF+2 < FRAME_CYCLES.
- PD_MODE, 2'b00: DAC power-down bits sent in every frame.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- sample_in  in  12  unsigned sample, MSB first on the wire.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  holding register empty; transfer when valid && ready.
- sclk  out  1  serial clock to DAC; idles high.
- sync_n  out  1  frame select, active low.
- sdata  out  1  serial data to DAC.
- busy  out  1  high while a frame is being shifted (sync_n low).
- frame_done  out  1  one-cycle pulse after the last bit.
- underrun  out  1  one-cycle pulse when a frame starts with no new sample.

## Operation
- Frame counter: 0..FRAME_CYCLES-1, free-running, wraps to 0. Frame tick = counter == FRAME_CYCLES-1.
- Holding register: `hold` (12b), `hold_full` flag, and `last` (12b, previous sample sent). sample_ready = ~hold_full. Handshake: sample_valid && sample_ready loads hold and sets hold_full on the same edge. sample_valid with ready low is ignored; the producer must hold it.
- Frame start (tick while in IDLE):
  - hold_full=1: word = {2'b00, PD_MODE, hold}, last←hold, hold_full←0.
  - hold_full=0: word = {2'b00, PD_MODE, last}, underrun pulses.
- Simultaneous accept and tick with hold empty: the sample goes into hold and is used in the next frame. The current frame repeats `last` and flags underrun.
- FSM:
  - IDLE: sync_n=1, sclk=1, busy=0. On tick → SHIFT, with bit index 15 and the phase counter cleared.
  - SHIFT: sync_n=0, busy=1, sdata=word[idx].
    - High phase: sclk=1 for SCLK_HALF cycles.
    - Low phase: sclk=0 for SCLK_HALF cycles. The DAC samples on the falling edge.
    - At the end of the low phase: if idx==0 → DONE, else idx−1.
  - DONE: one cycle, sync_n=1, sclk=1, busy=0, frame_done=1 → IDLE.
- A tick cannot arrive outside IDLE, given the FRAME_CYCLES constraint.
- Reset, at any time including mid-frame: aborts the frame immediately (sync_n=1, sclk=1) and clears hold_full and last. A partial frame is never resumed.

## Timing
- Reset values: sclk=1, sync_n=1, sdata=0, sample_ready=1, busy=0, frame_done=0, underrun=0. Counter, hold, last and idx are 0. FSM is in IDLE.
- First tick occurs FRAME_CYCLES−1 edges after reset release. sync_n falls on the following edge, and the first sample hits the wire FRAME_CYCLES clks after release.
- All outputs are registered.
- sdata[15] is valid from the edge where sync_n falls. Each bit is stable for 2·SCLK_HALF clks, centred on the sclk falling edge.
- SHIFT lasts exactly 32·SCLK_HALF clks (64 by default), then 1 DONE cycle.
- Frame start period is exactly FRAME_CYCLES clks.
- underrun is asserted in the first SHIFT cycle.
- sample_ready rises the cycle after hold is consumed, i.e. coincident with sync_n falling.
- Throughput: at most one sample per frame. Latency from accept to first bit on the wire is ≤ FRAME_CYCLES clks.

## Test plan
- Single sample: after reset, present 12'hA5C with valid=1 → accepted, ready=0. At frame start sync_n=0 for 64 clks; decoding on sclk falling edges gives 16'h0A5C. Then frame_done pulses, ready=1 and underrun=0.
- Underrun: no sample after the previous frame → next frame resends the same 16'h0A5C and underrun pulses once. With zero samples after reset → 16'h0000 and underrun.
- Back-pressure: valid held high with 12'h123 then 12'h456 → only 12'h123 is accepted until its frame starts. 12'h456 is accepted on the cycle ready rises, and the frames carry 123 then 456.
- Tick collision: accept 12'hFFF exactly on the tick cycle with hold empty → current frame repeats last and flags underrun. The next frame sends 16'h0FFF.
- Mid-frame reset: assert reset at bit 8 → sync_n=1 and sclk=1 immediately, ready=1. After release the first frame occurs FRAME_CYCLES clks later with 16'h0000 and underrun.
- Parameters: SCLK_HALF=1, PD_MODE=2'b11, FRAME_CYCLES=100 → period 100 clks, SHIFT 32 clks, word MS nibble = 4'b0011.

Source files
------------

// File: rtl/dac_serial_tx_if.sv
// Sample handshake between an audio producer and the serial DAC transmitter.
interface dac_serial_tx_if;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;

    // Producer side: drives samples, observes ready.
    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    // Transmitter side: consumes samples, drives ready.
    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: one 12-bit sample per frame, shifted MSB-first as
// {2'b00, PD_MODE, sample} over SYNC/SCLK/DIN. The block keeps its own frame
// timing and repeats the previous sample (flagging underrun) when starved.
module dac_serial_tx #(
    parameter int unsigned FRAME_CYCLES = 2268,
    parameter int unsigned SCLK_HALF    = 2,
    parameter logic [1:0]  PD_MODE      = 2'b00
) (
    input  logic            clk,
    input  logic            reset,
    dac_serial_tx_if.slave  smp,
    output logic            sclk,
    output logic            sync_n,
    output logic            sdata,
    output logic            busy,
    output logic            frame_done,
    output logic            underrun
);

    localparam int unsigned CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned PH_W     = $clog2(2 * SCLK_HALF);
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned IDX_W    = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    frame_cnt;
    logic [PH_W-1:0]     phase;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_m1;
    logic [WORD_W-1:0]   word;
    logic [WORD_W-1:0]   start_word;
    logic [SAMPLE_W-1:0] hold;
    logic [SAMPLE_W-1:0] last;
    logic                hold_full;
    logic                ready_q;
    logic                frame_tick;
    logic                frame_start;
    logic                accept;

    assign frame_tick  = (frame_cnt == CNT_W'(FRAME_CYCLES - 1));
    assign frame_start = frame_tick && (state == S_IDLE);
    assign accept      = smp.sample_valid && ready_q;
    assign start_word  = {2'b00, PD_MODE, (hold_full ? hold : last)};
    assign idx_m1      = idx - IDX_W'(1);

    // ready is kept as its own register, always the complement of hold_full
    assign smp.sample_ready = ready_q;

    // Free-running frame counter; the tick on its last count starts a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Single-entry holding register; a frame start drains it into last.
    // accept needs hold empty and the drain needs hold full, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            last      <= '0;
            hold_full <= 1'b0;
            ready_q   <= 1'b1;
        end else if (accept) begin
            hold      <= smp.sample_in;
            hold_full <= 1'b1;
            ready_q   <= 1'b0;
        end else if (frame_start && hold_full) begin
            last      <= hold;
            hold_full <= 1'b0;
            ready_q   <= 1'b1;
        end
    end

    // Frame FSM with registered SYNC/SCLK/DIN and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            phase      <= '0;
            word       <= '0;
            sclk       <= 1'b1;
            sync_n     <= 1'b1;
            sdata      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                S_IDLE: begin
                    sclk   <= 1'b1;
                    sync_n <= 1'b1;
                    busy   <= 1'b0;
                    if (frame_start) begin
                        state    <= S_SHIFT;
                        word     <= start_word;
                        idx      <= IDX_W'(WORD_W - 1);
                        phase    <= '0;
                        sync_n   <= 1'b0;
                        busy     <= 1'b1;
                        sdata    <= start_word[WORD_W-1];
                        underrun <= ~hold_full;
                    end
                end
                S_SHIFT: begin
                    if (phase == PH_W'(2 * SCLK_HALF - 1)) begin
                        // end of the low phase: next bit, or close the frame
                        phase <= '0;
                        sclk  <= 1'b1;
                        if (idx == '0) begin
                            state      <= S_DONE;
                            sync_n     <= 1'b1;
                            busy       <= 1'b0;
                            sdata      <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            idx   <= idx_m1;
                            sdata <= word[idx_m1];
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                        if (phase == PH_W'(SCLK_HALF - 1)) begin
                            sclk <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    sclk   <= 1'b1;
                    sync_n <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: frame-level vectors plus hand-written corner sequences.
module tb_dac_serial_tx;

    localparam int unsigned FRAME  = 2268;
    localparam int unsigned HALF   = 2;
    localparam int unsigned FRAME2 = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        reset2;
    logic [11:0] d_s;
    logic        d_v;
    logic        sel;
    longint      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    dac_serial_tx_if if1 ();
    dac_serial_tx_if if2 ();

    logic sclk1, sync1, sdata1, busy1, fd1, und1;
    logic sclk2, sync2, sdata2, busy2, fd2, und2;

    assign if1.sample_in    = d_s;
    assign if1.sample_valid = d_v & ~sel;
    assign if2.sample_in    = d_s;
    assign if2.sample_valid = d_v & sel;

    dac_serial_tx #(.FRAME_CYCLES(FRAME), .SCLK_HALF(HALF), .PD_MODE(2'b00)) u_dut (
        .clk(clk), .reset(reset), .smp(if1),
        .sclk(sclk1), .sync_n(sync1), .sdata(sdata1),
        .busy(busy1), .frame_done(fd1), .underrun(und1)
    );

    dac_serial_tx #(.FRAME_CYCLES(FRAME2), .SCLK_HALF(1), .PD_MODE(2'b11)) u_dut2 (
        .clk(clk), .reset(reset2), .smp(if2),
        .sclk(sclk2), .sync_n(sync2), .sdata(sdata2),
        .busy(busy2), .frame_done(fd2), .underrun(und2)
    );

    logic c_sclk, c_sync_n, c_sdata, c_busy, c_fd, c_und, c_ready;
    assign c_sclk   = sel ? sclk2  : sclk1;
    assign c_sync_n = sel ? sync2  : sync1;
    assign c_sdata  = sel ? sdata2 : sdata1;
    assign c_busy   = sel ? busy2  : busy1;
    assign c_fd     = sel ? fd2    : fd1;
    assign c_und    = sel ? und2   : und1;
    assign c_ready  = sel ? if2.sample_ready : if1.sample_ready;

    int n_run  = 0;
    int n_fail = 0;

    logic [15:0] cap_w;
    int          cap_low;
    int          cap_und_cnt;
    bit          cap_und_first;
    bit          cap_fd_ok;
    bit          cap_rdy;
    bit          cap_bsy_ok;
    bit          cap_to;
    longint      cap_t;
    longint      acc_cyc;

    typedef struct {
        bit          give;
        logic [11:0] s;
        logic [15:0] w;
        bit          und;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for SYNC to fall, then decodes bits on SCLK falling edges until SYNC rises.
    task automatic capture(input int budget);
        int  i;
        bit  prev;
        cap_w = '0; cap_low = 0; cap_und_cnt = 0; cap_und_first = 1'b0;
        cap_fd_ok = 1'b0; cap_rdy = 1'b0; cap_bsy_ok = 1'b1; cap_to = 1'b0; cap_t = 0;
        i = 0;
        @(negedge clk);
        while (c_sync_n !== 1'b0) begin
            if (i >= budget) begin
                cap_to = 1'b1;
                return;
            end
            i++;
            @(negedge clk);
        end
        cap_t         = cyc;
        cap_rdy       = c_ready;
        cap_und_first = c_und;
        prev          = 1'b1;
        while (c_sync_n === 1'b0 && cap_low < 1000) begin
            cap_low++;
            if (c_und === 1'b1) cap_und_cnt++;
            if (c_busy !== 1'b1) cap_bsy_ok = 1'b0;
            if (prev == 1'b1 && c_sclk === 1'b0) cap_w = {cap_w[14:0], c_sdata};
            prev = c_sclk;
            @(negedge clk);
        end
        cap_fd_ok = (c_fd === 1'b1) && (c_sclk === 1'b1) && (c_busy === 1'b0);
        if (c_und === 1'b1) cap_und_cnt++;
        @(negedge clk);
        if (c_fd !== 1'b0) cap_fd_ok = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] ew, input bit eu,
                               input int elow, input bit erdy, input longint tref,
                               input longint edt, input int budget);
        capture(budget);
        check({tag, "_timeout"}, 32'(cap_to), 32'd0);
        if (cap_to) return;
        check({tag, "_word"},      32'(cap_w), 32'(ew));
        check({tag, "_und_first"}, 32'(cap_und_first), 32'(eu));
        check({tag, "_und_count"}, 32'(cap_und_cnt), 32'(eu));
        check({tag, "_sync_low"},  32'(cap_low), 32'(elow));
        check({tag, "_done"},      32'(cap_fd_ok), 32'd1);
        check({tag, "_busy"},      32'(cap_bsy_ok), 32'd1);
        check({tag, "_ready"},     32'(cap_rdy), 32'(erdy));
        check({tag, "_period"},    32'(cap_t - tref), 32'(edt));
    endtask

    task automatic push(input logic [11:0] s, input int budget, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        d_s = s;
        d_v = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (c_ready === 1'b1) begin
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        d_v = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        longint tref;
        longint tf;
        longint bp_t1;
        bit     ok;
        bit     found;

        vecs[0] = '{1'b0, 12'h000, 16'h0000, 1'b1};
        vecs[1] = '{1'b1, 12'hA5C, 16'h0A5C, 1'b0};
        vecs[2] = '{1'b0, 12'h000, 16'h0A5C, 1'b1};
        vecs[3] = '{1'b1, 12'h800, 16'h0800, 1'b0};
        vecs[4] = '{1'b1, 12'h001, 16'h0001, 1'b0};

        reset = 1'b0; reset2 = 1'b0; d_s = '0; d_v = 1'b0; sel = 1'b0; acc_cyc = 0;
        repeat (3) @(negedge clk);
        check("rst_sclk",   32'(c_sclk),   32'd1);
        check("rst_sync_n", 32'(c_sync_n), 32'd1);
        check("rst_sdata",  32'(c_sdata),  32'd0);
        check("rst_ready",  32'(c_ready),  32'd1);
        check("rst_busy",   32'(c_busy),   32'd0);
        check("rst_done",   32'(c_fd),     32'd0);
        check("rst_und",    32'(c_und),    32'd0);

        reset = 1'b1;
        tref  = cyc;

        // frame-level vectors
        for (int k = 0; k < 5; k++) begin
            if (vecs[k].give) begin
                push(vecs[k].s, 10, ok);
                check($sformatf("vec%0d_push", k), 32'(ok), 32'd1);
                check($sformatf("vec%0d_ready_low", k), 32'(c_ready), 32'd0);
            end
            check_frame($sformatf("vec%0d", k), vecs[k].w, vecs[k].und, 64, 1'b1,
                        tref, longint'(FRAME), FRAME + 20);
            tref = cap_t;
        end

        // back-pressure: second sample waits until the first one's frame starts
        bp_t1 = 0;
        fork
            begin
                push(12'h123, 10, ok);
                check("bp_push1", 32'(ok), 32'd1);
                push(12'h456, FRAME + 20, ok);
                check("bp_push2", 32'(ok), 32'd1);
            end
            begin
                check_frame("bp1", 16'h0123, 1'b0, 64, 1'b1, tref, longint'(FRAME), FRAME + 20);
                bp_t1 = cap_t;
                tref  = cap_t;
                check_frame("bp2", 16'h0456, 1'b0, 64, 1'b1, tref, longint'(FRAME), FRAME + 20);
                tref  = cap_t;
            end
        join
        check("bp_accept_cycle", 32'(acc_cyc - bp_t1), 32'd0);

        // tick collision: accept exactly in the tick cycle with hold empty
        fork
            begin
                for (int i = 0; i < int'(FRAME) + 20 && cyc < tref + longint'(FRAME) - 1; i++)
                    @(negedge clk);
                check("col_ready_at_tick", 32'(c_ready), 32'd1);
                d_s = 12'hFFF;
                d_v = 1'b1;
                @(negedge clk);
                d_v = 1'b0;
                check("col_accepted", 32'(c_ready), 32'd0);
            end
            begin
                check_frame("col1", 16'h0456, 1'b1, 64, 1'b0, tref, longint'(FRAME), FRAME + 20);
                tref = cap_t;
            end
        join
        check_frame("col2", 16'h0FFF, 1'b0, 64, 1'b1, tref, longint'(FRAME), FRAME + 20);

        // mid-frame reset during bit 8, with a sample sitting in hold
        found = 1'b0;
        tf = 0;
        for (int i = 0; i < int'(FRAME) + 20; i++) begin
            @(negedge clk);
            if (c_sync_n === 1'b0) begin
                found = 1'b1;
                tf = cyc;
                break;
            end
        end
        check("mr_frame_found", 32'(found), 32'd1);
        push(12'h777, 4, ok);
        check("mr_push", 32'(ok), 32'd1);
        for (int i = 0; i < 64 && cyc < tf + 29; i++) @(negedge clk);
        check("mr_in_frame",    32'(c_sync_n), 32'd0);
        check("mr_ready_before", 32'(c_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mr_sync_n", 32'(c_sync_n), 32'd1);
        check("mr_sclk",   32'(c_sclk),   32'd1);
        check("mr_ready",  32'(c_ready),  32'd1);
        check("mr_busy",   32'(c_busy),   32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        tref  = cyc;
        check_frame("mr_after", 16'h0000, 1'b1, 64, 1'b1, tref, longint'(FRAME), FRAME + 20);

        // alternate parameter set on the second instance
        sel = 1'b1;
        @(negedge clk);
        reset2 = 1'b1;
        tref   = cyc;
        push(12'h3C5, 10, ok);
        check("p_push", 32'(ok), 32'd1);
        check_frame("p1", 16'h33C5, 1'b0, 32, 1'b1, tref, longint'(FRAME2), FRAME2 + 20);
        tref = cap_t;
        check_frame("p2", 16'h33C5, 1'b1, 32, 1'b1, tref, longint'(FRAME2), FRAME2 + 20);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
